inst_fetch_seq: RTL and testbench

- Instruction fetch sequencer: the producer side of the 32-bit Inst interface that the CU consumes.
- Generates instruction-memory addresses, runs a req/ack handshake with program memory, and buffers fetched words in a small prefetch FIFO.
- Presents each word to the CPU with a valid/ready handshake.
- Accepts branch redirects and halt requests from the CPU.

---
 rtl/inst_fetch_seq.sv | 197 +++++++++++++++++++
 tb/tb_inst_fetch_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_seq.sv
// inst_fetch_seq: instruction fetch sequencer.
//
// Walks a program counter and fetches one word at a time from program memory
// over a req/ack handshake. Fetched words go into a small prefetch FIFO and are
// offered to the CPU with a valid/ready handshake. The CPU can redirect the PC
// (branch) or hold off new fetches (halt).
//
// Ports:
//   CLK, Reset            clock, asynchronous active-high reset
//   mem_req/mem_addr      fetch request; address stable while mem_req is high
//   mem_ack/mem_rdata     one-cycle acknowledge with data in the same cycle
//   Inst/inst_pc          FIFO head word and its address (0 when empty)
//   inst_valid/inst_ready CPU handshake; pop on valid & ready
//   redirect/redirect_addr  one-cycle branch; flushes the FIFO, retargets PC
//   halt                  level; blocks new requests only
//   busy                  a memory request is outstanding
//   stall_cnt             (optional) cycles the CPU was ready but starved
//
// Optional feature macro: INST_FETCH_STALL_CNT_EN adds the stall_cnt output.
module inst_fetch_seq #(
  parameter int unsigned        ADDR_W   = 8,
  parameter int unsigned        DEPTH    = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              Reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       Inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              halt,
  output logic              busy
`ifdef INST_FETCH_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] DepthC = (PtrW+1)'(DEPTH);

  localparam logic [1:0] StRun   = 2'd0;
  localparam logic [1:0] StWait  = 2'd1;
  localparam logic [1:0] StFlush = 2'd2;  // request in flight whose data must be dropped

  logic [1:0]        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;

  logic [31:0]       fifo_data_q [DEPTH];
  logic [ADDR_W-1:0] fifo_pc_q   [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]     count_q, count_d;

  logic push, pop, flush;

  // Fetch control
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    flush      = 1'b0;
    if (redirect) begin
      flush      = 1'b1;
      fetch_pc_d = redirect_addr;
      if (state_q != StRun) begin
        if (mem_ack) begin
          // Data arriving with the redirect belongs to the old path.
          mem_req_d = 1'b0;
          state_d   = StRun;
        end else begin
          // Keep the handshake alive; the late data is dropped in StFlush.
          state_d = StFlush;
        end
      end
    end else begin
      case (state_q)
        StRun: begin
          if (!halt && (count_q < DepthC)) begin
            mem_req_d  = 1'b1;
            mem_addr_d = fetch_pc_q;
            state_d    = StWait;
          end
        end
        StWait: begin
          if (mem_ack) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
            mem_req_d  = 1'b0;
            state_d    = StRun;
          end
        end
        StFlush: begin
          if (mem_ack) begin
            mem_req_d = 1'b0;
            state_d   = StRun;
          end
        end
        default: begin
          mem_req_d = 1'b0;
          state_d   = StRun;
        end
      endcase
    end
  end

  assign pop = inst_valid && inst_ready && !redirect;

  // FIFO pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PtrW+1)'(1);
        2'b01:   count_d = count_q - (PtrW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q    <= StRun;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage needs no reset: contents are masked by count_q.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= mem_rdata;
      fifo_pc_q[wr_ptr_q]   <= mem_addr_q;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign busy       = (state_q != StRun);
  assign inst_valid = (count_q != '0);
  assign Inst       = inst_valid ? fifo_data_q[rd_ptr_q] : 32'h0;
  assign inst_pc    = inst_valid ? fifo_pc_q[rd_ptr_q] : '0;

`ifdef INST_FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (redirect) begin
      stall_cnt_d = 16'h0;
    end else if (inst_ready && !inst_valid && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      stall_cnt_q <= 16'h0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_seq.sv
// Bench for inst_fetch_seq: vector table, directed corner sequences, and a
// randomized run checked every cycle against a queue-based reference model.
module tb_inst_fetch_seq;

  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned DEPTH    = 2;
  localparam logic [7:0]  RESET_PC = 8'h00;

  logic        CLK;
  logic        Reset;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] Inst;
  logic [7:0]  inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect;
  logic [7:0]  redirect_addr;
  logic        halt;
  logic        busy;
`ifdef INST_FETCH_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  inst_fetch_seq #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .Inst          (Inst),
    .inst_pc       (inst_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .halt          (halt),
    .busy          (busy)
`ifdef INST_FETCH_STALL_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_chk;
  int n_pass;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model: fetched words as a queue, plus one in-flight request record.
  typedef struct packed {
    logic [31:0] w;
    logic [7:0]  pc;
  } ent_t;

  ent_t        mq[$];
  bit          m_pend;   // request outstanding
  bit          m_drop;   // its data will be discarded
  logic [7:0]  m_addr;
  logic [7:0]  m_fpc;
  logic [15:0] m_stall;

  function automatic void model_reset();
    mq.delete();
    m_pend  = 1'b0;
    m_drop  = 1'b0;
    m_addr  = RESET_PC;
    m_fpc   = RESET_PC;
    m_stall = 16'h0;
  endfunction

  function automatic void model_step(bit rdr, logic [7:0] raddr, bit ack, logic [31:0] rdata,
                                     bit hlt, bit rdy);
    int sz;
    bit was_pend;
    sz       = mq.size();
    was_pend = m_pend;
    if (rdr) m_stall = 16'h0;
    else if (rdy && sz == 0 && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    if (rdr) begin
      if (m_pend && ack) begin
        m_pend = 1'b0;
        m_drop = 1'b0;
      end else if (m_pend) begin
        m_drop = 1'b1;
      end
      mq.delete();
      m_fpc = raddr;
    end else begin
      if (sz > 0 && rdy) void'(mq.pop_front());
      if (was_pend && ack) begin
        if (!m_drop) begin
          mq.push_back({rdata, m_addr});
          m_fpc = m_fpc + 8'd1;
        end
        m_pend = 1'b0;
        m_drop = 1'b0;
      end else if (!was_pend && !hlt && sz < int'(DEPTH)) begin
        m_pend = 1'b1;
        m_addr = m_fpc;
      end
    end
  endfunction

  task automatic chk_model();
    logic [31:0] ew;
    logic [7:0]  ep;
    bit          ev;
    ev = (mq.size() > 0);
    ew = ev ? mq[0].w : 32'h0;
    ep = ev ? mq[0].pc : 8'h0;
    chk("model", 64'({mem_req, busy, inst_valid, mem_addr, inst_pc, Inst}),
        64'({m_pend, m_pend, ev, m_addr, ep, ew}));
`ifdef INST_FETCH_STALL_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
  endtask

  // One clock: drive at the falling edge, step the model at the rising edge,
  // compare at the next falling edge.
  task automatic cyc(input bit rst, input bit rdy, input bit hlt, input bit rdr,
                     input logic [7:0] raddr, input bit ack, input bit rnd);
    Reset         = rst;
    inst_ready    = rdy;
    halt          = hlt;
    redirect      = rdr;
    redirect_addr = raddr;
    mem_ack       = ack;
    mem_rdata     = rnd ? $urandom : (32'h1000 + {24'h0, mem_addr});
    if (rst) model_reset();
    @(posedge CLK);
    if (!rst) model_step(rdr, raddr, ack, mem_rdata, hlt, rdy);
    @(negedge CLK);
    chk_model();
  endtask

  typedef struct packed {
    bit         rst;
    bit         rdy;
    bit         ack;
    bit         er;
    logic [7:0] ea;
    bit         ev;
    logic [7:0] ep;
  } vec_t;

  vec_t tbl [14];

  initial begin
    bit hl;
    n_chk  = 0;
    n_pass = 0;
    Reset = 1'b1; inst_ready = 1'b0; halt = 1'b0; redirect = 1'b0;
    redirect_addr = 8'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    model_reset();

    // Expected outputs are those seen before the row's inputs take effect.
    tbl[0]  = '{rst:1, rdy:0, ack:0, er:0, ea:8'h00, ev:0, ep:8'h00};
    tbl[1]  = '{rst:0, rdy:1, ack:0, er:0, ea:8'h00, ev:0, ep:8'h00};
    tbl[2]  = '{rst:0, rdy:1, ack:1, er:1, ea:8'h00, ev:0, ep:8'h00};
    tbl[3]  = '{rst:0, rdy:1, ack:0, er:0, ea:8'h00, ev:1, ep:8'h00};
    tbl[4]  = '{rst:0, rdy:0, ack:1, er:1, ea:8'h01, ev:0, ep:8'h00};
    tbl[5]  = '{rst:0, rdy:0, ack:0, er:0, ea:8'h01, ev:1, ep:8'h01};
    tbl[6]  = '{rst:0, rdy:0, ack:1, er:1, ea:8'h02, ev:1, ep:8'h01};
    tbl[7]  = '{rst:0, rdy:0, ack:0, er:0, ea:8'h02, ev:1, ep:8'h01};
    tbl[8]  = '{rst:0, rdy:0, ack:0, er:0, ea:8'h02, ev:1, ep:8'h01};
    tbl[9]  = '{rst:0, rdy:1, ack:0, er:0, ea:8'h02, ev:1, ep:8'h01};
    tbl[10] = '{rst:0, rdy:1, ack:0, er:0, ea:8'h02, ev:1, ep:8'h02};
    tbl[11] = '{rst:0, rdy:0, ack:0, er:1, ea:8'h03, ev:0, ep:8'h00};
    tbl[12] = '{rst:0, rdy:0, ack:1, er:1, ea:8'h03, ev:0, ep:8'h00};
    tbl[13] = '{rst:0, rdy:0, ack:0, er:0, ea:8'h03, ev:1, ep:8'h03};

    @(negedge CLK);
    @(negedge CLK);
    chk("reset_busy", 64'(busy), 64'(0));

    for (int i = 0; i < 14; i++) begin
      logic [31:0] ei;
      ei = tbl[i].ev ? (32'h1000 + {24'h0, tbl[i].ep}) : 32'h0;
      chk($sformatf("tbl[%0d]", i), 64'({mem_req, mem_addr, inst_valid, inst_pc, Inst}),
          64'({tbl[i].er, tbl[i].ea, tbl[i].ev, tbl[i].ep, ei}));
      cyc(tbl[i].rst, tbl[i].rdy, 1'b0, 1'b0, 8'h0, tbl[i].ack, 1'b0);
    end

    // Redirect while a word is buffered and a request is in flight.
    cyc(1, 0, 0, 0, 8'h00, 0, 0);
    cyc(0, 0, 0, 0, 8'h00, 0, 0);
    chk("rd_req0", 64'({mem_req, mem_addr}), 64'({1'b1, 8'h00}));
    cyc(0, 0, 0, 0, 8'h00, 1, 0);
    cyc(0, 0, 0, 0, 8'h00, 0, 0);
    chk("rd_pre", 64'({mem_req, mem_addr, inst_valid}), 64'({1'b1, 8'h01, 1'b1}));
    cyc(0, 0, 0, 1, 8'h40, 0, 0);
    chk("rd_flush", 64'({inst_valid, mem_req, mem_addr, busy}), 64'({1'b0, 1'b1, 8'h01, 1'b1}));
    cyc(0, 0, 0, 0, 8'h00, 1, 0);
    chk("rd_discard", 64'({mem_req, inst_valid, busy}), 64'(0));
    cyc(0, 0, 0, 0, 8'h00, 0, 0);
    chk("rd_target", 64'({mem_req, mem_addr}), 64'({1'b1, 8'h40}));
    cyc(0, 0, 0, 0, 8'h00, 1, 0);
    chk("rd_first", 64'({inst_valid, inst_pc, Inst}), 64'({1'b1, 8'h40, 32'h1040}));

    // PC wrap past 0xFF.
    cyc(0, 1, 0, 1, 8'hFE, 0, 0);
    chk("wr_clear", 64'({inst_valid, mem_req}), 64'(0));
    cyc(0, 1, 0, 0, 8'h00, 0, 0);
    chk("wr_fe", 64'({mem_req, mem_addr}), 64'({1'b1, 8'hFE}));
    cyc(0, 1, 0, 0, 8'h00, 1, 0);
    chk("wr_fe_pc", 64'({inst_valid, inst_pc}), 64'({1'b1, 8'hFE}));
    cyc(0, 1, 0, 0, 8'h00, 0, 0);
    chk("wr_ff", 64'({mem_req, mem_addr}), 64'({1'b1, 8'hFF}));
    cyc(0, 1, 0, 0, 8'h00, 1, 0);
    cyc(0, 1, 0, 0, 8'h00, 0, 0);
    chk("wr_00", 64'({mem_req, mem_addr}), 64'({1'b1, 8'h00}));
    cyc(0, 1, 0, 0, 8'h00, 1, 0);
    chk("wr_00_inst", 64'({inst_valid, inst_pc, Inst}), 64'({1'b1, 8'h00, 32'h1000}));

    // Halt raised while waiting on address 5.
    cyc(0, 0, 0, 1, 8'h05, 0, 0);
    cyc(0, 0, 0, 0, 8'h00, 0, 0);
    chk("hl_req5", 64'({mem_req, mem_addr}), 64'({1'b1, 8'h05}));
    cyc(0, 0, 1, 0, 8'h00, 0, 0);
    chk("hl_hold", 64'({mem_req, mem_addr}), 64'({1'b1, 8'h05}));
    cyc(0, 0, 1, 0, 8'h00, 1, 0);
    chk("hl_push", 64'({inst_valid, inst_pc, mem_req}), 64'({1'b1, 8'h05, 1'b0}));
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 0, 8'h00, 0, 0);
      chk("hl_noreq", 64'(mem_req), 64'(0));
    end
    cyc(0, 1, 1, 0, 8'h00, 0, 0);
    chk("hl_pop", 64'({inst_valid, mem_req}), 64'(0));
    cyc(0, 0, 0, 0, 8'h00, 0, 0);
    chk("hl_resume", 64'({mem_req, mem_addr}), 64'({1'b1, 8'h06}));

    // Reset in the middle of a request, then a stale ack.
    Reset = 1'b1;
    #1;
    chk("rs_now", 64'({mem_req, inst_valid, Inst, busy}), 64'(0));
    cyc(1, 0, 0, 0, 8'h00, 1, 0);
    cyc(0, 0, 0, 0, 8'h00, 1, 0);
    chk("rs_restart", 64'({mem_req, mem_addr, inst_valid}), 64'({1'b1, RESET_PC, 1'b0}));

    // Randomized traffic against the model.
    hl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      bit a, r, rs, rdy;
      logic [7:0] ra;
      if ($urandom_range(0, 19) == 0) hl = ~hl;
      a   = mem_req ? ($urandom_range(0, 9) < 6) : ($urandom_range(0, 19) == 0);
      r   = ($urandom_range(0, 15) == 0);
      ra  = 8'($urandom);
      rs  = ($urandom_range(0, 399) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      cyc(rs, rdy, hl, r, ra, a, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
